// File: rtl/display_scan_driver.sv
// display_scan_driver: time-multiplexes six BCD clock digits onto one
// common-anode 7-segment bus with per-digit anode enables.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   sec_unit..hour_ten  BCD digits from the counter chain
//   set_sel          field being set (00 none, 01 sec, 10 min, 11 hours)
//   tick_second      one-clock pulse per second (colon blink only)
//   an[5:0]          active-low digit enables, an[0]=sec_unit .. an[5]=hour_ten
//   seg[6:0]         active-low segments, seg[0]=a .. seg[6]=g
//   dp               active-low decimal point used as the colon
//
// Optional build macro: COLON_BLINK_EN makes the colon blink with tick_second.
module display_scan_driver #(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned BLINK_DIV   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_unit,
  input  logic [3:0] sec_ten,
  input  logic [3:0] min_unit,
  input  logic [3:0] min_ten,
  input  logic [3:0] hour_unit,
  input  logic [3:0] hour_ten,
  input  logic [1:0] set_sel,
  input  logic       tick_second,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned P_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned FC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [P_W-1:0]   p_q, p_d;
  logic [2:0]       idx_q, idx_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             blink_q, blink_d;
  logic [1:0]       sel_prev_q, sel_prev_d;
  logic [23:0]      snap_q, snap_d;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             colon_on_c;

  logic             p_last_c;
  logic             frame_end_c;
  logic             sel_clear_c;
  logic [3:0]       cur_digit_c;
  logic [1:0]       field_c;

`ifdef COLON_BLINK_EN
  logic colon_q, colon_d;

  always_comb begin
    colon_d = colon_q ^ tick_second;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) colon_q <= 1'b0;
    else     colon_q <= colon_d;
  end

  assign colon_on_c = colon_q;
`else
  logic unused_tick;
  assign unused_tick = tick_second;
  assign colon_on_c  = 1'b1;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Scan counters, frame snapshot and blink timing.
  always_comb begin
    p_last_c    = (p_q == P_W'(SCAN_DIV - 1));
    frame_end_c = p_last_c && (idx_q == 3'd5);
    sel_clear_c = (set_sel == 2'b00) || (set_sel != sel_prev_q);

    p_d        = p_last_c ? '0 : p_q + P_W'(1);
    idx_d      = idx_q;
    fc_d       = fc_q;
    blink_d    = blink_q;
    sel_prev_d = set_sel;
    snap_d     = snap_q;

    if (p_last_c) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    if (frame_end_c) snap_d = {hour_ten, hour_unit, min_ten, min_unit, sec_ten, sec_unit};

    // A new or cleared selection restarts the blink so the field starts visible.
    if (sel_clear_c) begin
      fc_d    = '0;
      blink_d = 1'b0;
    end else if (frame_end_c) begin
      if (fc_q == FC_W'(BLINK_DIV - 1)) begin
        fc_d    = '0;
        blink_d = ~blink_q;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end
  end

  // Digit currently addressed by the scan index.
  always_comb begin
    cur_digit_c = snap_q[3:0];
    case (idx_q)
      3'd0:    cur_digit_c = snap_q[3:0];
      3'd1:    cur_digit_c = snap_q[7:4];
      3'd2:    cur_digit_c = snap_q[11:8];
      3'd3:    cur_digit_c = snap_q[15:12];
      3'd4:    cur_digit_c = snap_q[19:16];
      3'd5:    cur_digit_c = snap_q[23:20];
      default: cur_digit_c = snap_q[3:0];
    endcase
    field_c = idx_q[2:1] + 2'd1;
  end

  // Output image: dead time > leading zero > blink > decode.
  always_comb begin
    an_d  = 6'b111111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (p_q >= P_W'(DEAD_CYCLES)) begin
      an_d = ~(6'd1 << idx_q);
      if ((idx_q == 3'd5) && (cur_digit_c == 4'd0)) begin
        seg_d = 7'b1111111;
      end else if (blink_q && (set_sel == field_c)) begin
        seg_d = 7'b1111111;
      end else begin
        seg_d = seg_decode(cur_digit_c);
      end
      if (((idx_q == 3'd2) || (idx_q == 3'd4)) && colon_on_c) dp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q        <= '0;
      idx_q      <= 3'd0;
      fc_q       <= '0;
      blink_q    <= 1'b0;
      sel_prev_q <= 2'b00;
      snap_q     <= '0;
      an_q       <= 6'b111111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      p_q        <= p_d;
      idx_q      <= idx_d;
      fc_q       <= fc_d;
      blink_q    <= blink_d;
      sel_prev_q <= sel_prev_d;
      snap_q     <= snap_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver with a frame-level reference model.
module tb_display_scan_driver;

  localparam int SD    = 4;
  localparam int DC    = 1;
  localparam int BD    = 2;
  localparam int FRAME = 6 * SD;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  logic       clk;
  logic       rst;
  logic [3:0] dig [6];
  logic [1:0] set_sel;
  logic       tick_second;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  display_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .rst         (rst),
    .sec_unit    (dig[0]),
    .sec_ten     (dig[1]),
    .min_unit    (dig[2]),
    .min_ten     (dig[3]),
    .hour_unit   (dig[4]),
    .hour_ten    (dig[5]),
    .set_sel     (set_sel),
    .tick_second (tick_second),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: time since release, latched digits, frames since
  // the selection was last (re)made, and seconds ticks seen.
  int         t;
  logic [3:0] snap [6];
  int         frames_sel;
  logic [1:0] sel_prev;
  int         ticks;
  logic [6:0] seg_tab [16];

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
  end

  task automatic chk(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                  name, $time, act.an, act.seg, act.dp, exp.an, exp.seg, exp.dp);
  endtask

  function automatic out_t blank_out();
    out_t o;
    o.an = 6'b111111; o.seg = 7'b1111111; o.dp = 1'b1;
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    int   p, idx;
    logic blink_on, colon_ok;
    o   = blank_out();
    p   = t % SD;
    idx = (t / SD) % 6;
    if (p >= DC) begin
      o.an     = 6'b111111 & ~(6'd1 << idx);
      blink_on = (((frames_sel / BD) % 2) == 1) && (set_sel != 2'b00) &&
                 ((idx / 2) == (int'(set_sel) - 1));
      if (idx == 5 && snap[5] == 4'd0) o.seg = 7'b1111111;
      else if (blink_on)               o.seg = 7'b1111111;
      else                             o.seg = seg_tab[snap[idx]];
`ifdef COLON_BLINK_EN
      colon_ok = (ticks % 2) == 1;
`else
      colon_ok = 1'b1;
`endif
      if ((idx == 2 || idx == 4) && colon_ok) o.dp = 1'b0;
    end
    return o;
  endfunction

  // One clock: called at a negedge with inputs already set for the coming posedge.
  task automatic step(input logic r);
    logic fe;
    rst = r;
    if (r) begin
      exp_q.push_back(blank_out());
      t = 0; frames_sel = 0; sel_prev = 2'b00; ticks = 0;
      for (int i = 0; i < 6; i++) snap[i] = 4'd0;
    end else begin
      exp_q.push_back(model_out());
      fe = (t % FRAME) == FRAME - 1;
      if (fe) for (int i = 0; i < 6; i++) snap[i] = dig[i];
      if (set_sel == 2'b00 || set_sel != sel_prev) frames_sel = 0;
      else if (fe) frames_sel++;
      sel_prev = set_sel;
      if (tick_second) ticks++;
      t++;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) dig[$urandom_range(5)] = 4'($urandom_range(15));
      if ($urandom_range(99) == 0) set_sel = 2'($urandom_range(3));
      tick_second = ($urandom_range(29) == 0);
      step(1'b0);
    end
    tick_second = 1'b0;
  endtask

  // Monitor: every clock after reset, compare the DUT against the oldest expectation.
  always @(posedge clk) begin
    out_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scan", {an, seg, dp}, e);
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    set_sel = 2'b00;
    tick_second = 1'b0;
    for (int i = 0; i < 6; i++) dig[i] = 4'd0;
    #1;
    chk("reset_blank", {an, seg, dp}, blank_out());
    @(negedge clk);
    step(1'b1); step(1'b1); step(1'b1);

    // Digits 1..6 with hour_ten=1 down to sec_unit=6.
    dig[5] = 4'd1; dig[4] = 4'd2; dig[3] = 4'd3; dig[2] = 4'd4; dig[1] = 4'd5; dig[0] = 4'd6;
    run(3 * FRAME);

    // Leading zero on hour_ten and an invalid code on sec_unit.
    dig[5] = 4'd0; dig[0] = 4'hC;
    run(2 * FRAME);

    // Mid-frame change of min_unit must wait for the next frame.
    dig[2] = 4'd3;
    run(FRAME);
    guard = 0;
    while (((t / SD) % 6) != 1 && guard < FRAME) begin
      step(1'b0);
      guard++;
    end
    dig[2] = 4'd7;
    run(2 * FRAME);

    // Blink minutes, then move to hours mid-blank.
    set_sel = 2'b10;
    run(3 * FRAME + SD);
    set_sel = 2'b11;
    run(6 * FRAME);
    set_sel = 2'b00;
    run(FRAME);

    // Colon pulses.
    tick_second = 1'b1; step(1'b0); tick_second = 1'b0;
    run(FRAME);
    tick_second = 1'b1; step(1'b0); tick_second = 1'b0;
    run(FRAME);

    rand_run(1500);

    // Asynchronous reset mid-slot blanks without a clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {an, seg, dp}, blank_out());
    @(negedge clk);
    step(1'b1); step(1'b1);
    rand_run(600);

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
